// File: rtl/seq_magnitude_comparator_if.sv
// Operand/result bundle for the bit-serial magnitude comparator.
// The master side issues compare requests; the slave side (the comparator)
// returns busy/done and the one-hot L/E/G relation.
interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             L;
  logic             E;
  logic             G;

  modport master (
    output start,
    output signed_mode,
    output a_in,
    output b_in,
    input  busy,
    input  done,
    input  L,
    input  E,
    input  G
  );

  modport slave (
    input  start,
    input  signed_mode,
    input  a_in,
    input  b_in,
    output busy,
    output done,
    output L,
    output E,
    output G
  );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// Bit-serial magnitude comparator.
// Compares two WIDTH-bit operands one bit per clock, LSB first, in unsigned
// or two's-complement mode. Operands are captured in parallel on start and
// shifted out internally. Because later (higher) bits always override the
// running relation, scanning LSB first still yields the correct magnitude
// order once the top bit has been seen. The top bit is treated as a sign bit
// in signed mode, which simply inverts the sense of a mismatch there.
module seq_magnitude_comparator #(
  parameter int WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  seq_magnitude_comparator_if.slave   bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REL_EQ = 2'd0,
    REL_LT = 2'd1,
    REL_GT = 2'd2
  } rel_t;

  // Fold one operand bit pair into the running relation. Equal bits leave the
  // relation alone; a differing bit decides it outright. On the sign bit of a
  // signed compare a set bit means "more negative", so the sense flips.
  function automatic rel_t bit_rel(input rel_t rel_in, input logic a_bit,
                                   input logic b_bit, input logic sign_bit);
    rel_t r;
    r = rel_in;
    if (a_bit != b_bit) begin
      if (sign_bit) r = a_bit ? REL_LT : REL_GT;
      else          r = a_bit ? REL_GT : REL_LT;
    end
    return r;
  endfunction

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CNT_W-1:0] cnt;
  logic             mode_r;
  rel_t             rel;
  rel_t             rel_nx;
  logic             load;
  logic             finish;
  logic             last_bit;

  assign last_bit = (cnt == LAST);
  assign bus.busy = (state_q == RUN);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: accept start only when idle or holding a result, and
  // finish once the top bit has been folded in.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_d = DONE;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Relation after folding in the current LSB pair.
  always_comb begin
    rel_nx = bit_rel(rel, sa[0], sb[0], last_bit & mode_r);
  end

  // Operand shift registers, bit counter and running relation.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      cnt    <= '0;
      mode_r <= 1'b0;
      rel    <= REL_EQ;
    end else if (load) begin
      sa     <= bus.a_in;
      sb     <= bus.b_in;
      mode_r <= bus.signed_mode;
      cnt    <= '0;
      rel    <= REL_EQ;
    end else if (state_q == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      rel <= rel_nx;
      // Hold the counter on the last bit so it never wraps inside a run.
      if (!finish) cnt <= cnt + 1'b1;
    end
  end

  // Result registers: written only on completion, held across new starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.done <= 1'b0;
      bus.L    <= 1'b0;
      bus.E    <= 1'b0;
      bus.G    <= 1'b0;
    end else begin
      bus.done <= finish;
      if (finish) begin
        bus.L <= (rel_nx == REL_LT);
        bus.E <= (rel_nx == REL_EQ);
        bus.G <= (rel_nx == REL_GT);
      end
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Testbench for seq_magnitude_comparator: 32-bit and 8-bit instances,
// directed corner cases plus randomized operands against a reference model
// built on plain integer comparisons.
module tb_seq_magnitude_comparator;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  seq_magnitude_comparator_if #(.WIDTH(32)) bus32 ();
  seq_magnitude_comparator_if #(.WIDTH(8))  bus8 ();

  seq_magnitude_comparator #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  seq_magnitude_comparator #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {L,E,G} from ordinary integer comparison.
  function automatic logic [2:0] model32(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (s) return {sa < sb, sa == sb, sa > sb};
    return {a < b, a == b, a > b};
  endfunction

  function automatic logic [2:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic signed [7:0] sa, sb;
    sa = a;
    sb = b;
    if (s) return {sa < sb, sa == sb, sa > sb};
    return {a < b, a == b, a > b};
  endfunction

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output int lat, output int bcyc, output logic [2:0] leg, output logic done_after);
    bus32.a_in = a; bus32.b_in = b; bus32.signed_mode = s; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    lat = 1; bcyc = 0; leg = 3'b000; done_after = 1'b1;
    while (!bus32.done && lat < 200) begin
      if (bus32.busy) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
    leg = {bus32.L, bus32.E, bus32.G};
    @(posedge clk); #1;
    done_after = bus32.done;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      output int lat, output int bcyc, output logic [2:0] leg, output logic done_after);
    bus8.a_in = a; bus8.b_in = b; bus8.signed_mode = s; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    lat = 1; bcyc = 0; leg = 3'b000; done_after = 1'b1;
    while (!bus8.done && lat < 100) begin
      if (bus8.busy) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
    leg = {bus8.L, bus8.E, bus8.G};
    @(posedge clk); #1;
    done_after = bus8.done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if ({bus32.busy, bus32.done, bus32.L, bus32.E, bus32.G} !== 5'b0) begin
      n_err++;
      $display("FAIL reset32: busy/done/L/E/G=%b required 00000",
               {bus32.busy, bus32.done, bus32.L, bus32.E, bus32.G});
    end
    n_cmp++;
    if ({bus8.busy, bus8.done, bus8.L, bus8.E, bus8.G} !== 5'b0) begin
      n_err++;
      $display("FAIL reset8: busy/done/L/E/G=%b required 00000",
               {bus8.busy, bus8.done, bus8.L, bus8.E, bus8.G});
    end
  endtask

  task automatic test_directed32();
    logic [31:0] av[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
    logic [31:0] bv[5] = '{32'd123, 32'd123, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h1234_5678};
    logic        sv[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0]  ev[5] = '{3'b001, 3'b100, 3'b001, 3'b100, 3'b010};
    int lat, bcyc;
    logic [2:0] leg;
    logic da;
    for (int i = 0; i < 5; i++) begin
      run32(av[i], bv[i], sv[i], lat, bcyc, leg, da);
      n_cmp++;
      if (leg !== ev[i]) begin
        n_err++;
        $display("FAIL dir32[%0d] LEG: got %b required %b", i, leg, ev[i]);
      end
      n_cmp++;
      if (lat !== 33) begin
        n_err++;
        $display("FAIL dir32[%0d] latency: got %0d required 33", i, lat);
      end
      n_cmp++;
      if (bcyc !== 32) begin
        n_err++;
        $display("FAIL dir32[%0d] busy cycles: got %0d required 32", i, bcyc);
      end
      n_cmp++;
      if (da !== 1'b0) begin
        n_err++;
        $display("FAIL dir32[%0d] done width: done still %b one cycle later, required 0", i, da);
      end
    end
    // Equal operands in unsigned mode too.
    run32(32'h1234_5678, 32'h1234_5678, 1'b0, lat, bcyc, leg, da);
    n_cmp++;
    if (leg !== 3'b010) begin
      n_err++;
      $display("FAIL dir32 equal unsigned LEG: got %b required 010", leg);
    end
  endtask

  task automatic test_ignore_start();
    int npulse = 0;
    int tfirst = 0;
    logic [2:0] leg = 3'b000;
    bus32.a_in = 32'd7; bus32.b_in = 32'd9; bus32.signed_mode = 1'b0; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      if (c == 10) begin
        bus32.a_in = 32'hFFFF_FFFF; bus32.b_in = 32'd0; bus32.start = 1'b1;
      end else begin
        bus32.start = 1'b0;
      end
      if (bus32.done) begin
        if (npulse == 0) begin
          tfirst = c;
          leg = {bus32.L, bus32.E, bus32.G};
        end
        npulse++;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (npulse !== 1) begin
      n_err++;
      $display("FAIL ignore_start pulses: got %0d required 1", npulse);
    end
    n_cmp++;
    if (tfirst !== 33) begin
      n_err++;
      $display("FAIL ignore_start done cycle: got %0d required 33", tfirst);
    end
    n_cmp++;
    if (leg !== model32(32'd7, 32'd9, 1'b0)) begin
      n_err++;
      $display("FAIL ignore_start LEG: got %b required %b", leg, model32(32'd7, 32'd9, 1'b0));
    end
  endtask

  task automatic test_mid_reset();
    int npulse = 0;
    int lat, bcyc;
    logic [2:0] leg;
    logic da;
    bus32.a_in = 32'd100; bus32.b_in = 32'd1; bus32.signed_mode = 1'b0; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    repeat (14) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({bus32.busy, bus32.done} !== 2'b00) begin
      n_err++;
      $display("FAIL mid_reset busy/done: got %b required 00", {bus32.busy, bus32.done});
    end
    n_cmp++;
    if ({bus32.L, bus32.E, bus32.G} !== 3'b000) begin
      n_err++;
      $display("FAIL mid_reset LEG: got %b required 000", {bus32.L, bus32.E, bus32.G});
    end
    for (int c = 0; c < 40; c++) begin
      if (bus32.done || bus32.busy) npulse++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (npulse !== 0) begin
      n_err++;
      $display("FAIL mid_reset activity: got %0d busy/done cycles required 0", npulse);
    end
    run32(32'd1, 32'd100, 1'b0, lat, bcyc, leg, da);
    n_cmp++;
    if (leg !== 3'b100 || lat !== 33) begin
      n_err++;
      $display("FAIL mid_reset restart: LEG %b lat %0d required 100 lat 33", leg, lat);
    end
  endtask

  task automatic test_back_to_back();
    int np = 0;
    int t[2] = '{0, 0};
    logic [2:0] lg[2] = '{3'b000, 3'b000};
    bus32.a_in = 32'd5; bus32.b_in = 32'd3; bus32.signed_mode = 1'b0; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.a_in = 32'd3; bus32.b_in = 32'd5;
    for (int c = 1; c <= 100 && np < 2; c++) begin
      if (bus32.done) begin
        t[np] = c;
        lg[np] = {bus32.L, bus32.E, bus32.G};
        np++;
        if (np == 2) bus32.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus32.start = 1'b0;
    n_cmp++;
    if (np !== 2) begin
      n_err++;
      $display("FAIL b2b pulses: got %0d required 2", np);
    end
    n_cmp++;
    if (t[0] !== 33 || t[1] - t[0] !== 33) begin
      n_err++;
      $display("FAIL b2b timing: first %0d spacing %0d required 33/33", t[0], t[1] - t[0]);
    end
    n_cmp++;
    if (lg[0] !== 3'b001 || lg[1] !== 3'b100) begin
      n_err++;
      $display("FAIL b2b LEG: got %b,%b required 001,100", lg[0], lg[1]);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_random32();
    int lat, bcyc;
    logic [2:0] leg, exp;
    logic da;
    logic [31:0] a, b;
    logic s;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = (i % 5 == 0) ? a : ((i % 3 == 0) ? (a ^ (32'h1 << $urandom_range(31, 0))) : $urandom);
      s = $urandom_range(1, 0);
      exp = model32(a, b, s);
      run32(a, b, s, lat, bcyc, leg, da);
      n_cmp++;
      if (leg !== exp || lat !== 33) begin
        n_err++;
        $display("FAIL rand32[%0d] a=%h b=%h s=%b: LEG %b lat %0d required %b lat 33",
                 i, a, b, s, leg, lat, exp);
      end
    end
  endtask

  task automatic test_width8();
    int lat, bcyc;
    logic [2:0] leg, exp;
    logic da;
    logic [7:0] a, b;
    logic s;
    run8(8'hFF, 8'h01, 1'b1, lat, bcyc, leg, da);
    n_cmp++;
    if (leg !== 3'b100 || lat !== 9 || bcyc !== 8) begin
      n_err++;
      $display("FAIL w8 signed FF/01: LEG %b lat %0d busy %0d required 100 9 8", leg, lat, bcyc);
    end
    run8(8'hFF, 8'h01, 1'b0, lat, bcyc, leg, da);
    n_cmp++;
    if (leg !== 3'b001 || da !== 1'b0) begin
      n_err++;
      $display("FAIL w8 unsigned FF/01: LEG %b done_after %b required 001 0", leg, da);
    end
    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom);
      b = (i % 4 == 0) ? a : 8'($urandom);
      s = $urandom_range(1, 0);
      exp = model8(a, b, s);
      run8(a, b, s, lat, bcyc, leg, da);
      n_cmp++;
      if (leg !== exp || lat !== 9) begin
        n_err++;
        $display("FAIL rand8[%0d] a=%h b=%h s=%b: LEG %b lat %0d required %b lat 9",
                 i, a, b, s, leg, lat, exp);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus32.start = 1'b0; bus32.signed_mode = 1'b0; bus32.a_in = '0; bus32.b_in = '0;
    bus8.start = 1'b0;  bus8.signed_mode = 1'b0;  bus8.a_in = '0;  bus8.b_in = '0;
    test_reset();
    test_directed32();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_random32();
    test_width8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_magnitude_comparator.md
# seq_magnitude_comparator

Parametrised bit-serial magnitude comparator that compares two WIDTH-bit operands one bit per clock, LSB first, in unsigned or two's-complement signed mode. It replaces the fixed 32-bit serial comparator fed by external shift registers. Operands load in parallel with a start/busy/done handshake, and the block contains its own operand shift registers. It sits beside the datapath as a multi-cycle compare unit for the lab ALU/FSM experiments.

## Interface
- WIDTH, 32, operand width in bits; legal range 2..64
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a compare; sampled only when the block is not busy
- signed_mode  input  1  0 = unsigned, 1 = two's-complement signed; sampled with start
- a_in  input  WIDTH  operand A; sampled with start
- b_in  input  WIDTH  operand B; sampled with start
- busy  output  1  high while a compare is in progress
- done  output  1  one-cycle pulse when the result becomes valid
- L  output  1  A < B
- E  output  1  A == B
- G  output  1  A > B

## Operation
- States:
  - IDLE: no result yet since reset.
  - RUN: compare in progress.
  - DONE: result valid and held.
- IDLE or DONE with start=1: load a_in/b_in into shift registers sa/sb, latch signed_mode into mode_r, clear bit counter cnt, set rel=EQ, go to RUN.
- RUN, each cycle: examine sa[0]/sb[0], then shift sa/sb right by 1 and increment cnt.
- Relation update for bit i (i = cnt):
  - if a_i == b_i: rel is unchanged.
  - if i < WIDTH-1, or mode_r=0: rel = a_i ? GT : LT.
  - if i == WIDTH-1 and mode_r=1 (sign bit): rel = a_i ? LT : GT.
  - Higher bits always override lower bits; this gives correct LSB-first magnitude order.
- After the bit with cnt==WIDTH-1 is processed: write rel to L/E/G (exactly one high), pulse done, go to DONE.
- DONE: L/E/G hold their value until the next result is written. Starting a new compare does not clear them.
- start while busy=1 is ignored; in-flight operands are unaffected.
- rst (any state): go to IDLE, clear sa, sb, cnt and rel. Outputs take their reset values, and an in-flight compare is discarded with no done pulse.
- cnt width is $clog2(WIDTH); cnt never wraps during RUN.

## Timing
- Reset values: busy=0, done=0, L=0, E=0, G=0 (no valid result after reset).
- start is sampled at edge T0.
- busy is high from T0+1 through T0+WIDTH inclusive (WIDTH cycles).
- At edge T0+WIDTH the last bit is processed. From T0+WIDTH+1, L/E/G show the new result and done=1 for exactly one cycle, with busy=0.
- Total latency is WIDTH+1 cycles from the start edge to done being visible.
- start asserted in the cycle done is high is accepted, because the block is not busy. busy rises the next cycle and back-to-back throughput is one compare per WIDTH+1 cycles.
- If start and rst are high together, rst wins.

## Test plan
- Unsigned, WIDTH=32, A=0xFFFFFFFF, B=123, start pulse -> after 33 cycles done=1, G=1, L=0, E=0; busy high for exactly 32 cycles.
- Signed mode, same operands (A = -1) -> L=1, E=0, G=0; done arrives at the same cycle as in the unsigned case.
- A=0x80000000, B=0x7FFFFFFF: unsigned -> G=1; signed -> L=1. A=B=0x12345678 in either mode -> E=1.
- Drive start again with different operands at cycle 10 of a run -> ignored; the first result is unchanged and no extra done pulse appears.
- Assert rst at cycle 15 of a run -> the next cycle has busy=0, done=0, L=E=G=0 and no done pulse. A fresh start then completes normally.
- Back-to-back: hold start=1 continuously with A=5,B=3 then A=3,B=5 -> results G then L, with done pulses 33 cycles apart. Also repeat the suite with WIDTH=8 (0xFF vs 0x01 signed -> L).
